// File: rtl/self_con_ctrl.sv
// self_con_ctrl -- self-convergence sequencer for BISG_TOP.
//
// Repeatedly resets and runs the BISG, converts each run's captured speed
// code into a path delay (dmax), and grows ScanNum by a doubling step until
// K_THR consecutive run-to-run deltas are <= EPS ps. It also captures the
// first signature of a sequence as golden and flags later mismatches.
//
// Optional feature macro: SELF_CON_TIMEOUT_EN
//   defined   : 24-bit watchdog over WAITLO+RUN; expiry ends the sequence
//               with o_timeout=1, o_converged=0.
//   undefined : no watchdog, o_timeout tied 0, WAITLO/RUN wait forever.
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_go             1-cycle start pulse (accepted only in IDLE/DONE)
//   i_over           BISG run-complete flag
//   i_scan_done      BISG signature-valid strobe (rising edge counted)
//   i_sig            BISG signature
//   i_speed          BISG captured speed code
//   o_bisg_rst_n     active-low reset to BISG_TOP
//   o_scan_num       ScanNum driven to BISG_TOP
//   o_pass           last counted signature matched golden
//   o_sig_err        sticky mismatch flag for the current sequence
//   o_dmax           delay of the last completed run, ps
//   o_run_cnt        completed runs this sequence
//   o_busy           sequence in progress (not IDLE/DONE)
//   o_converged      K_THR qualifying deltas reached (valid in DONE)
//   o_timeout        watchdog abort
//   o_dbg_state      current FSM state encoding
//
// Handshake: i_go is a level sampled each cycle and acts only in IDLE/DONE.
// A BISG run is framed by i_over: after the BISG reset is released the
// sequencer waits for i_over==0 (run started), then for i_over==1 (run
// complete); i_speed must be stable in the cycle after i_over is seen high.
// i_scan_done is counted on its rising edge and only while in RUN.
module self_con_ctrl #(
  parameter int SIG_W      = 13,
  parameter int SCAN_START = 60,
  parameter int SCAN_BASE  = 10,
  parameter int K_THR      = 8,
  parameter int EPS        = 10,
  parameter int MAX_RUNS   = 64,
  parameter int RST_CYC    = 3,
  parameter int MULT_MAX   = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_over,
  input  logic             i_scan_done,
  input  logic [SIG_W-1:0] i_sig,
  input  logic [9:0]       i_speed,
  output logic             o_bisg_rst_n,
  output logic [19:0]      o_scan_num,
  output logic             o_pass,
  output logic             o_sig_err,
  output logic [13:0]      o_dmax,
  output logic [6:0]       o_run_cnt,
  output logic             o_busy,
  output logic             o_converged,
  output logic             o_timeout,
  output logic [2:0]       o_dbg_state
);

  localparam int          RC_W        = $clog2(RST_CYC + 1);
  localparam logic [RC_W-1:0] LP_RC_LAST = RC_W'(RST_CYC - 1);
  localparam logic [19:0] LP_SCAN_START = 20'(SCAN_START);
  localparam logic [20:0] LP_SCAN_BASE  = 21'(SCAN_BASE);
  localparam logic [7:0]  LP_K_THR      = 8'(K_THR);
  localparam logic [13:0] LP_EPS        = 14'(EPS);
  localparam logic [6:0]  LP_MAX_RUNS   = 7'(MAX_RUNS);
  localparam logic [7:0]  LP_MULT_MAX   = 8'(MULT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTB, S_WAITLO, S_RUN, S_EVAL, S_UPD, S_DONE
  } state_t;

  state_t          r_state;
  logic [RC_W-1:0] r_rst_cnt;
  logic            r_bisg_rst_n;
  logic [19:0]     r_scan_num;
  logic            r_pass;
  logic            r_sig_err;
  logic [13:0]     r_dmax;
  logic [13:0]     r_prev_dmax;
  logic [6:0]      r_run_cnt;
  logic            r_busy;
  logic            r_converged;
  logic [6:0]      r_mult;
  logic [7:0]      r_cnt_k;
  logic            r_golden_vld;
  logic [SIG_W-1:0] r_golden;
  logic            r_scan_done_q;

  logic            w_sd_rise;
  logic [13:0]     w_dmax_calc;
  logic            w_qualify;
  logic [7:0]      w_mult_x2;
  logic [6:0]      w_mult_next;
  logic [7:0]      w_cnt_k_next;
  logic [20:0]     w_scan_sum;
  logic [19:0]     w_scan_next;
  logic [6:0]      w_run_cnt_next;
  logic            w_wd_expire;

  assign w_sd_rise   = i_scan_done & ~r_scan_done_q;
  // Speed codes above 20 fall in the upper delay band (extra 100 ps offset).
  assign w_dmax_calc = (i_speed > 10'd20) ? 14'd1000 + 14'(i_speed) * 14'd10
                                          : 14'd900  + 14'(i_speed) * 14'd10;

  // A decrease never qualifies; the >= test guards the subtraction from wrap.
  assign w_qualify   = (r_run_cnt != 7'd0) && (r_dmax >= r_prev_dmax) &&
                       ((r_dmax - r_prev_dmax) <= LP_EPS);
  assign w_mult_x2   = {r_mult, 1'b0};
  assign w_mult_next = !w_qualify ? r_mult :
                       (w_mult_x2 > LP_MULT_MAX) ? LP_MULT_MAX[6:0] : w_mult_x2[6:0];
  // Any non-qualifying delta breaks the consecutive streak.
  assign w_cnt_k_next   = w_qualify ? r_cnt_k + 8'd1 : 8'd0;
  assign w_scan_sum     = {1'b0, r_scan_num} + 21'(w_mult_next) * LP_SCAN_BASE;
  assign w_scan_next    = (w_scan_sum > 21'h0FFFFF) ? 20'hFFFFF : w_scan_sum[19:0];
  assign w_run_cnt_next = r_run_cnt + 7'd1;

`ifdef SELF_CON_TIMEOUT_EN
  logic [23:0] r_wd;
  logic        r_timeout;
  logic        w_go_accept;
  assign w_go_accept = i_go && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wd_expire = (r_wd == 24'hFFFFFF);

  // Counts only while waiting on the BISG; any other state clears it,
  // so every RSTB entry starts a fresh window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_WAITLO || r_state == S_RUN) r_wd <= r_wd + 24'd1;
      else                                         r_wd <= '0;
      if (w_go_accept) r_timeout <= 1'b0;
      else if (w_wd_expire && (r_state == S_WAITLO || r_state == S_RUN))
        r_timeout <= 1'b1;
    end
  end
  assign o_timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_rst_cnt     <= '0;
      r_bisg_rst_n  <= 1'b1;
      r_scan_num    <= LP_SCAN_START;
      r_pass        <= 1'b0;
      r_sig_err     <= 1'b0;
      r_dmax        <= '0;
      r_prev_dmax   <= '0;
      r_run_cnt     <= '0;
      r_busy        <= 1'b0;
      r_converged   <= 1'b0;
      r_mult        <= 7'd1;
      r_cnt_k       <= '0;
      r_golden_vld  <= 1'b0;
      r_golden      <= '0;
      r_scan_done_q <= 1'b0;
    end else begin
      r_scan_done_q <= i_scan_done;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_go) begin
            r_state      <= S_RSTB;
            r_bisg_rst_n <= 1'b0;
            r_rst_cnt    <= '0;
            r_scan_num   <= LP_SCAN_START;
            r_mult       <= 7'd1;
            r_cnt_k      <= '0;
            r_run_cnt    <= '0;
            r_sig_err    <= 1'b0;
            r_golden_vld <= 1'b0;
            r_converged  <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_RSTB: begin
          if (r_rst_cnt == LP_RC_LAST) begin
            r_state      <= S_WAITLO;
            r_bisg_rst_n <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_WAITLO: begin
          if (w_wd_expire) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_converged <= 1'b0;
          end else if (!i_over) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_wd_expire) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_converged <= 1'b0;
          end else if (i_over) begin
            r_state <= S_EVAL;
          end
          if (w_sd_rise) begin
            if (!r_golden_vld) begin
              r_golden     <= i_sig;
              r_golden_vld <= 1'b1;
              r_pass       <= 1'b1;
            end else begin
              r_pass <= (i_sig == r_golden);
              if (i_sig != r_golden) r_sig_err <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          r_dmax  <= w_dmax_calc;
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_cnt_k     <= w_cnt_k_next;
          r_mult      <= w_mult_next;
          r_prev_dmax <= r_dmax;
          r_run_cnt   <= w_run_cnt_next;
          r_scan_num  <= w_scan_next;
          if (w_cnt_k_next == LP_K_THR) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_converged <= 1'b1;
          end else if (w_run_cnt_next == LP_MAX_RUNS) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_converged <= 1'b0;
          end else begin
            r_state      <= S_RSTB;
            r_bisg_rst_n <= 1'b0;
            r_rst_cnt    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bisg_rst_n = r_bisg_rst_n;
  assign o_scan_num   = r_scan_num;
  assign o_pass       = r_pass;
  assign o_sig_err    = r_sig_err;
  assign o_dmax       = r_dmax;
  assign o_run_cnt    = r_run_cnt;
  assign o_busy       = r_busy;
  assign o_converged  = r_converged;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_self_con_ctrl.sv
// Bench for self_con_ctrl: directed runs with a spec-level model that is
// compared against the DUT outputs every cycle, plus literal checkpoints.
module tb_self_con_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        over;
  logic        scan_done;
  logic [12:0] sig;
  logic [9:0]  speed;

  logic        o_bisg_rst_n;
  logic [19:0] o_scan_num;
  logic        o_pass;
  logic        o_sig_err;
  logic [13:0] o_dmax;
  logic [6:0]  o_run_cnt;
  logic        o_busy;
  logic        o_converged;
  logic        o_timeout;
  logic [2:0]  o_dbg_state;

  always #5 clk = ~clk;

  self_con_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_over(over),
    .i_scan_done(scan_done), .i_sig(sig), .i_speed(speed),
    .o_bisg_rst_n(o_bisg_rst_n), .o_scan_num(o_scan_num), .o_pass(o_pass),
    .o_sig_err(o_sig_err), .o_dmax(o_dmax), .o_run_cnt(o_run_cnt),
    .o_busy(o_busy), .o_converged(o_converged), .o_timeout(o_timeout),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [13:0] exp_q[$];   // expected dmax per run, in run order

  // Model state: expected output values after the next rising edge.
  bit m_rstn, m_pass, m_err, m_busy, m_conv, m_gvld;
  int m_scan, m_dmax, m_run_cnt, m_mult, m_cnt_k, m_prev, m_golden;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int dmax_of(input int spd);
    return (spd > 20) ? 1000 + 10 * spd : 900 + 10 * spd;
  endfunction

  task automatic model_reset();
    m_rstn = 1; m_scan = 60; m_pass = 0; m_err = 0; m_dmax = 0; m_run_cnt = 0;
    m_busy = 0; m_conv = 0; m_mult = 1; m_cnt_k = 0; m_prev = 0; m_gvld = 0;
    m_golden = 0;
  endtask

  task automatic model_go();
    m_scan = 60; m_mult = 1; m_cnt_k = 0; m_run_cnt = 0; m_err = 0; m_gvld = 0;
    m_conv = 0; m_busy = 1; m_rstn = 0;
  endtask

  task automatic model_sig(input int s);
    if (!m_gvld) begin
      m_golden = s; m_gvld = 1; m_pass = 1;
    end else begin
      m_pass = (s == m_golden);
      if (s != m_golden) m_err = 1;
    end
  endtask

  task automatic model_upd(output bit done);
    bit q;
    q = (m_run_cnt > 0) && (m_dmax >= m_prev) && (m_dmax - m_prev <= 10);
    if (q) begin
      m_cnt_k++;
      m_mult = (m_mult * 2 > 64) ? 64 : m_mult * 2;
    end else begin
      m_cnt_k = 0;
    end
    m_prev = m_dmax;
    m_run_cnt++;
    m_scan = m_scan + m_mult * 10;
    if (m_scan > 'hFFFFF) m_scan = 'hFFFFF;
    done = (m_cnt_k == 8) || (m_run_cnt == 64);
    m_conv = (m_cnt_k == 8);
    if (done) m_busy = 0;
    else      m_rstn = 0;
  endtask

  // Compare process: every cycle, just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("rstn",      32'(o_bisg_rst_n), 32'(m_rstn));
      chk("scan_num",  32'(o_scan_num),   32'(m_scan));
      chk("pass",      32'(o_pass),       32'(m_pass));
      chk("sig_err",   32'(o_sig_err),    32'(m_err));
      chk("dmax",      32'(o_dmax),       32'(m_dmax));
      chk("run_cnt",   32'(o_run_cnt),    32'(m_run_cnt));
      chk("busy",      32'(o_busy),       32'(m_busy));
      chk("converged", 32'(o_converged),  32'(m_conv));
      chk("timeout",   32'(o_timeout),    32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the RSTB-entry edge.
  task automatic start_seq();
    go = 1;
    model_go();
    tick();
    go = 0;
  endtask

  // One BISG run, entered one negedge after RSTB entry.
  // smode: 0 none, 1 pulse 0x0A5A, 2 pulse 0x1234, 3 held strobe,
  //        4 ignored strobe in RSTB then pulse 0x0A5A.
  task automatic run_body(input int spd, input int smode, input bit go_busy,
                          input bit rst_mid, output bit done);
    done  = 0;
    over  = 0;
    speed = 10'(spd);
    if (smode == 4) begin scan_done = 1; sig = 13'h1234; end
    tick();
    scan_done = 0;
    tick();
    m_rstn = 1;          // third low cycle ends at the coming edge
    tick();              // WAITLO sees over==0
    tick();              // now in RUN
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin
          if (smode == 1 || smode == 4 || smode == 3) begin
            scan_done = 1; sig = 13'h0A5A; model_sig(13'h0A5A);
          end else if (smode == 2) begin
            scan_done = 1; sig = 13'h1234; model_sig(13'h1234);
          end
        end
        1: if (smode == 3) sig = 13'h1234; else scan_done = 0;
        3: scan_done = 0;
        4: if (go_busy) go = 1;
        5: go = 0;
        6: if (rst_mid) begin
          rst = 1;
          model_reset();
          tick();
          rst = 0;
          done = 1;
          return;
        end
        default: ;
      endcase
      tick();
    end
    exp_q.push_back(14'(dmax_of(spd)));
    over = 1;
    tick();
    m_dmax = int'(exp_q.pop_front());
    tick();
    model_upd(done);
    tick();
  endtask

  // ---------------- stimulus ----------------
  bit done;
  initial begin
    rst = 1; go = 0; over = 0; scan_done = 0; sig = '0; speed = '0;
    model_reset();
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();

    chk("lit_rst_scan",  32'(o_scan_num),   32'd60);
    chk("lit_rst_rstn",  32'(o_bisg_rst_n), 32'd1);
    chk("lit_rst_busy",  32'(o_busy),       32'd0);
    chk("lit_rst_dmax",  32'(o_dmax),       32'd0);

    // Sequence A: constant speed 30 converges after 9 runs.
    start_seq();
    done = 0;
    for (int r = 0; r < 20 && !done; r++) begin
      int sm;
      sm = (r == 0) ? 1 : (r == 1) ? 4 : (r == 2) ? 2 : (r == 3) ? 1 : (r == 4) ? 3 : 0;
      run_body(30, sm, r == 2, 1'b0, done);
    end
    chk("lit_a_runs",   32'(o_run_cnt),   32'd9);
    chk("lit_a_scan",   32'(o_scan_num),  32'd2610);
    chk("lit_a_conv",   32'(o_converged), 32'd1);
    chk("lit_a_dmax",   32'(o_dmax),      32'd1300);
    chk("lit_a_err",    32'(o_sig_err),   32'd1);
    chk("lit_a_pass",   32'(o_pass),      32'd1);

    // Sequence B: dmax band boundaries, then reset in the middle of run 3.
    start_seq();
    chk("lit_b_errclr", 32'(o_sig_err),   32'd0);
    chk("lit_b_convclr",32'(o_converged), 32'd0);
    run_body(15, 0, 1'b0, 1'b0, done);
    chk("lit_dmax_s15", 32'(o_dmax), 32'd1050);
    run_body(21, 0, 1'b0, 1'b0, done);
    chk("lit_dmax_s21", 32'(o_dmax), 32'd1210);
    run_body(20, 0, 1'b0, 1'b0, done);
    chk("lit_dmax_s20", 32'(o_dmax), 32'd1100);
    chk("lit_b_scan",   32'(o_scan_num), 32'd90);
    run_body(30, 0, 1'b0, 1'b1, done);
    chk("lit_mrst_busy", 32'(o_busy),       32'd0);
    chk("lit_mrst_scan", 32'(o_scan_num),   32'd60);
    chk("lit_mrst_runs", 32'(o_run_cnt),    32'd0);
    chk("lit_mrst_dmax", 32'(o_dmax),       32'd0);
    chk("lit_mrst_rstn", 32'(o_bisg_rst_n), 32'd1);
    tick();

    // Sequence C: alternating 30/29 never builds a streak -> run cap.
    start_seq();
    done = 0;
    for (int r = 0; r < 70 && !done; r++)
      run_body((r % 2) ? 29 : 30, 0, 1'b0, 1'b0, done);
    chk("lit_c_runs", 32'(o_run_cnt),   32'd64);
    chk("lit_c_conv", 32'(o_converged), 32'd0);
    chk("lit_c_busy", 32'(o_busy),      32'd0);
    chk("lit_c_dmax", 32'(o_dmax),      32'd1290);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
